// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal/vertical counters plus registered sync,
// visible-area, coordinate and per-frame strobe outputs.
// All outputs are flops loaded from the next-state counter values, so every
// output describes the same (h, v) position as the counters themselves.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             VIDEO_ON,
  output logic [CNT_W-1:0] PIXEL_X,
  output logic [CNT_W-1:0] PIXEL_Y,
  output logic             FRAME_START,
  output logic             VBLANK_TICK
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;
  logic             vblank_tick_q, vblank_tick_d;
  logic             h_wrap;
  logic             v_wrap;

  // Next position: advance along the line, wrap to the next line, wrap the frame.
  always_comb begin
    h_wrap  = (h_cnt_q == H_MAX);
    v_wrap  = (v_cnt_q == V_MAX);
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Decode outputs for the position the counters are about to hold.
  always_comb begin
    video_on_d    = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    hsync_d       = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = h_wrap && v_wrap;
    vblank_tick_d = h_wrap && (v_cnt_q == V_LAST_VIS);
  end

  // State and output registers; reset parks at (0,0) blanked with syncs idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_tick_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      vblank_tick_q <= vblank_tick_d;
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign VIDEO_ON    = video_on_q;
  assign PIXEL_X     = h_cnt_q;
  assign PIXEL_Y     = v_cnt_q;
  assign FRAME_START = frame_start_q;
  assign VBLANK_TICK = vblank_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a reduced
// active-high-sync instance, both checked every cycle against a model that
// derives position from the number of counting edges since reset.
module tb_vga_sync_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  // default-parameter instance
  logic       d_hs, d_vs, d_vid, d_fs, d_vbt;
  logic [9:0] d_x, d_y;
  vga_sync_gen u_dflt (
    .CLK(clk), .RST(rst_d), .HSYNC(d_hs), .VSYNC(d_vs), .VIDEO_ON(d_vid),
    .PIXEL_X(d_x), .PIXEL_Y(d_y), .FRAME_START(d_fs), .VBLANK_TICK(d_vbt)
  );

  // reduced frame, active-high syncs: H 8/2/2/2 (14), V 4/1/1/1 (7)
  logic       s_hs, s_vs, s_vid, s_fs, s_vbt;
  logic [9:0] s_x, s_y;
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .CNT_W(10)
  ) u_small (
    .CLK(clk), .RST(rst_s), .HSYNC(s_hs), .VSYNC(s_vs), .VIDEO_ON(s_vid),
    .PIXEL_X(s_x), .PIXEL_Y(s_y), .FRAME_START(s_fs), .VBLANK_TICK(s_vbt)
  );

  // ---------------- reference model ----------------
  // n = counting edges since the last reset edge. Position is n in mixed radix
  // (line length, frame length); strobes fire on frame multiples / offsets.
  function automatic logic [24:0] expect_out(input int n, input bit in_rst,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb, input bit pol);
    int ht, vt, fr, x, y;
    bit hsa, vsa, vid, fs, vbt;
    logic [9:0] xx, yy;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    fr  = ht * vt;
    x   = n % ht;
    y   = (n / ht) % vt;
    hsa = !in_rst && (x >= hv + hf) && (x < hv + hf + hs);
    vsa = !in_rst && (y >= vv + vf) && (y < vv + vf + vs);
    vid = !in_rst && (x < hv) && (y < vv);
    fs  = !in_rst && (n > 0) && (n % fr == 0);
    vbt = !in_rst && (n % fr == vv * ht);
    xx  = 10'(x);
    yy  = 10'(y);
    return {hsa ? pol : !pol, vsa ? pol : !pol, vid, fs, vbt, xx, yy};
  endfunction

  int n_d = 0, n_s = 0;
  bit r_d = 1'b0, r_s = 1'b0;
  bit ok_d = 1'b0, ok_s = 1'b0;

  // model state advances on each rising edge from the sampled reset
  always @(posedge clk) begin
    if (rst_d) begin n_d <= 0; r_d <= 1'b1; ok_d <= 1'b1; end
    else begin n_d <= n_d + 1; r_d <= 1'b0; end
    if (rst_s) begin n_s <= 0; r_s <= 1'b1; ok_s <= 1'b1; end
    else begin n_s <= n_s + 1; r_s <= 1'b0; end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [24:0] exp_d, exp_s, act_d, act_s;
  always @(negedge clk) begin
    if (ok_d) begin
      exp_d = expect_out(n_d, r_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      act_d = {d_hs, d_vs, d_vid, d_fs, d_vbt, d_x, d_y};
      vectors++;
      if (act_d !== exp_d) begin
        miscompares++;
        $display("FAIL dflt_cycle n=%0d got {hs,vs,vid,fs,vbt,x,y}=%b,%b,%b,%b,%b,%0d,%0d want %b,%b,%b,%b,%b,%0d,%0d",
          n_d, act_d[24], act_d[23], act_d[22], act_d[21], act_d[20], act_d[19:10], act_d[9:0],
          exp_d[24], exp_d[23], exp_d[22], exp_d[21], exp_d[20], exp_d[19:10], exp_d[9:0]);
      end
    end
    if (ok_s) begin
      exp_s = expect_out(n_s, r_s, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1);
      act_s = {s_hs, s_vs, s_vid, s_fs, s_vbt, s_x, s_y};
      vectors++;
      if (act_s !== exp_s) begin
        miscompares++;
        $display("FAIL small_cycle n=%0d got {hs,vs,vid,fs,vbt,x,y}=%b,%b,%b,%b,%b,%0d,%0d want %b,%b,%b,%b,%b,%0d,%0d",
          n_s, act_s[24], act_s[23], act_s[22], act_s[21], act_s[20], act_s[19:10], act_s[9:0],
          exp_s[24], exp_s[23], exp_s[22], exp_s[21], exp_s[20], exp_s[19:10], exp_s[9:0]);
      end
    end
  end

  // ---------------- hand-computed literal checks ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- default instance driver ----------------
  task automatic run_default();
    int lo_cnt, fall_x, rise_x, vfall_x, prev_hs, prev_vid, found;
    rst_d = 1'b1;
    repeat (5) @(negedge clk);
    check("d_rst_x", d_x, 0);
    check("d_rst_y", d_y, 0);
    check("d_rst_vid", d_vid, 0);
    check("d_rst_hs", d_hs, 1);
    check("d_rst_vs", d_vs, 1);
    check("d_rst_strobes", {d_fs, d_vbt}, 0);
    rst_d = 1'b0;
    @(negedge clk);
    check("d_rel_x", d_x, 1);
    check("d_rel_vid", d_vid, 1);
    check("d_rel_fs", d_fs, 0);
    // one full line from x=1 to the next x=1
    lo_cnt = 0; fall_x = -1; rise_x = -1; vfall_x = -1;
    prev_hs = d_hs; prev_vid = d_vid;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (d_hs == 1'b0) lo_cnt++;
      if (prev_hs == 1 && d_hs == 1'b0) fall_x = d_x;
      if (prev_hs == 0 && d_hs == 1'b1) rise_x = d_x;
      if (prev_vid == 1 && d_vid == 1'b0) vfall_x = d_x;
      prev_hs = d_hs; prev_vid = d_vid;
    end
    check("d_hs_low_cycles", lo_cnt, 96);
    check("d_hs_fall_x", fall_x, 656);
    check("d_hs_rise_x", rise_x, 752);
    check("d_vid_fall_x", vfall_x, 640);
    check("d_line_x", d_x, 1);
    check("d_line_y", d_y, 1);
    // random run lengths with random-length resets
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(20, 1700)) @(negedge clk);
      rst_d = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      check("d_midrst_x", d_x, 0);
      check("d_midrst_vid", d_vid, 0);
      rst_d = 1'b0;
    end
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (d_x == 10'd656) found = 1;
    end
    check("d_reach_656", found, 1);
    check("d_hs_at_656", d_hs, 0);
  endtask

  // ---------------- reduced instance driver ----------------
  task automatic run_small();
    int found, gap, vb_cnt, vb_x, vb_y;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    check("s_rst_hs", s_hs, 0);
    rst_s = 1'b0;
    // run to (5,3) then pulse reset for one edge
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (s_x == 10'd5 && s_y == 10'd3) found = 1;
    end
    check("s_reach_5_3", found, 1);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    check("s_midrst_pos", {s_x, s_y}, 0);
    check("s_midrst_vid", s_vid, 0);
    check("s_midrst_sync", {s_hs, s_vs}, 0);
    check("s_midrst_strobes", {s_fs, s_vbt}, 0);
    @(negedge clk);
    check("s_resume_x", s_x, 1);
    check("s_resume_y", s_y, 0);
    // wait for a frame start, then measure to the next one
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (s_fs) found = 1;
    end
    check("s_first_fs", found, 1);
    gap = 0; found = 0; vb_cnt = 0; vb_x = -1; vb_y = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      gap++;
      if (s_vbt) begin vb_cnt++; vb_x = s_x; vb_y = s_y; end
      if (s_fs) found = 1;
    end
    check("s_fs_period", gap, 98);
    check("s_vb_per_frame", vb_cnt, 1);
    check("s_vb_x", vb_x, 0);
    check("s_vb_y", vb_y, 4);
    // random segments separated by random resets
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 250)) @(negedge clk);
      rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_s = 1'b0;
    end
    repeat (120) @(negedge clk);
  endtask

  // ---------------- main + final report ----------------
  initial begin
    fork
      run_default();
      run_small();
    join
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // watchdog
  initial begin
    #(40 * 60000);
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
